token_fifo_mc: RTL
==================

Name: token_fifo_mc

Overview:
- Multi-channel elastic token buffer between Link/PE/RE stages.
- Carries forward tokens {v,a,c,r,d} downstream and backward tokens {n,t,v,c} upstream, with one independent FIFO and one fsm_token controller per channel.
- Generalises the fixed-depth single-channel LinkOut FIFO with these additions:
  - configurable depth, width and channel count;
  - early nack with slack;
  - terminate-driven flush (rEVERT);
  - a sticky overflow flag.

Parameters:
- WIDTH_DATA, 32, data field width per token.
- NUM_CHANNEL, 2, number of independent channels.
- DEPTH, 16, entries per channel, including the output register; power of two, at least 4.
- SLACK, 2, entries held in reserve after nack is raised; 1 ≤ SLACK < DEPTH.

Ports:
- clock, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous active-low reset.
- I_FTk, in, NUM_CHANNEL*(WIDTH_DATA+4), upstream forward tokens.
  - Channel k occupies bits [k*(WIDTH_DATA+4) +: WIDTH_DATA+4].
  - Within a channel, the order is {v,a,c,r,d} with v at the MSB.
- O_BTk, out, NUM_CHANNEL*4, upstream backward tokens; per channel the order is {n,t,v,c}.
- O_FTk, out, NUM_CHANNEL*(WIDTH_DATA+4), downstream forward tokens; same layout as I_FTk.
- I_BTk, in, NUM_CHANNEL*4, downstream backward tokens; same layout as O_BTk.
- O_Overflow, out, NUM_CHANNEL, per-channel sticky overflow flag.

Behaviour:
- Reset (reset=0, asynchronous): every channel is cleared.
  - Count=0, pointers=0, state=eMPTY.
  - O_FTk=0, O_BTk=0, O_Overflow=0.
  - Reset applied mid-operation discards all stored tokens with no further outputs.
- Channels are fully independent; the rules below apply per channel.
- Count rules:
  - Count spans 0..DEPTH; its width is $clog2(DEPTH)+1.
  - RAM pointers wrap modulo DEPTH-1 slots; the output register holds the head token.
- Push: occurs on a clock edge where I_FTk.v=1 and (count<DEPTH, or a pop happens in the same cycle).
  - Stores {a,c,r,d}.
  - If I_FTk.v=1 and count==DEPTH with no pop, the token is dropped and O_Overflow is set. It stays set until reset.
- Pop (accept): O_FTk.v=1 and I_BTk.n=0 in the same cycle. The head advances at that edge.
- Latency: a token pushed into an empty channel at edge N appears on O_FTk at edge N+1 (1 cycle).
  - Back-to-back tokens stream at 1 per cycle while I_BTk.n=0.
- O_FTk hold: while I_BTk.n=1, O_FTk stays stable (all fields), including when v=1.
- O_BTk.n (registered): 1 when the next-state count ≥ DEPTH-SLACK.
  - With SLACK ≥ 1, a compliant upstream that stops 1 cycle after seeing n never overflows.
- O_BTk.v (registered): pulses 1 for one cycle after each accepted push.
- O_BTk.c: I_BTk.c delayed by one register stage.
- O_BTk.t: 1 only during rEVERT.
- fsm_token states:
  - eMPTY: count=0, O_FTk.v=0. A push goes to fILL.
  - fILL: O_FTk.v=1 and not stalled.
    - I_BTk.n=1 goes to wAIT.
    - A pop with no push that leaves count=0 goes to eMPTY.
  - wAIT: O_FTk.v=1, stalled by I_BTk.n. I_BTk.n=0 goes to fILL (that cycle is a pop).
  - rEVERT: entered from any state when I_BTk.t=1.
    - At that edge, count=0, pointers=0 and O_FTk.v=0.
    - Lasts exactly 1 cycle with O_BTk.t=1, then goes to eMPTY.
    - Pushes during rEVERT are discarded without setting O_Overflow.
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged; allowed at count==DEPTH.
  - Push and I_BTk.t in the same cycle: t wins and the token is discarded.
  - I_BTk.t during rEVERT: extends rEVERT by 1 cycle.
- The a, c and r fields are passed through unmodified; the block does not interpret the release bit.

Test Plan:
- Reset, then single token d=0x0000_00A5, a=1, r=0 pushed on ch0 at cycle 1:
  - O_FTk ch0 = {v=1,a=1,c=0,r=0,d=0xA5} at cycle 2;
  - O_BTk.v ch0 pulses at cycle 2;
  - ch1 stays 0.
- DEPTH=16, SLACK=2, I_BTk.n=1 held on ch0, 20 consecutive pushes d=0..19:
  - O_BTk.n rises once 14 entries are stored;
  - pushes 16..19 are dropped and O_Overflow[0]=1;
  - after releasing n, exactly d=0..15 appear in order, 1 per cycle, then eMPTY.
- Alternating I_BTk.n=1/0 every cycle on a stream d=1..8:
  - O_FTk is stable across each stalled cycle;
  - all 8 tokens are delivered once each, in order, with no duplicates.
- Full channel (count=16) with a push and a pop in the same cycle:
  - the token is accepted, count stays 16, O_Overflow stays 0.
- 5 tokens stored, then I_BTk.t=1 for 1 cycle together with a push:
  - next cycle O_FTk.v=0 and O_BTk.t=1 for exactly 1 cycle, then state eMPTY;
  - the coincident push is lost and O_Overflow is unchanged.
- reset deasserted→asserted mid-stream with 7 tokens stored: all outputs go to 0 immediately (asynchronously), and no tokens appear after release.

Source files
------------

// File: rtl/token_fifo_mc.sv
// rtl/token_fifo_mc.sv - multi-channel elastic token FIFO with slack nack, revert flush and sticky overflow
// Each channel keeps its head token in an output register backed by a (DEPTH-1)-slot RAM.
module token_fifo_mc #(
   parameter int WIDTH_DATA  = 32,
   parameter int NUM_CHANNEL = 2,
   parameter int DEPTH       = 16,
   parameter int SLACK       = 2
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [NUM_CHANNEL*(WIDTH_DATA+4)-1:0] I_FTk,
   output logic [NUM_CHANNEL*4-1:0]              O_BTk,
   output logic [NUM_CHANNEL*(WIDTH_DATA+4)-1:0] O_FTk,
   input  logic [NUM_CHANNEL*4-1:0]              I_BTk,
   output logic [NUM_CHANNEL-1:0]                O_Overflow
);
   localparam int FW    = WIDTH_DATA + 4;
   localparam int PW    = WIDTH_DATA + 3;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int SLOTS = DEPTH - 1;

   typedef enum logic [1:0] {S_EMPTY, S_FILL, S_WAIT, S_REVERT} state_e;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(SLOTS - 1)) ? '0 : p + 1'b1;
   endfunction

   for (genvar k = 0; k < NUM_CHANNEL; k++) begin : g_ch
      logic          in_v;
      logic [PW-1:0] in_pl;
      logic          bt_n, bt_t, bt_c;
      logic          unused_bt_v;
      logic [PW-1:0] mem_q [SLOTS];
      logic          mem_we;
      state_e        state_q, state_d;
      logic [CW-1:0] count_q, count_d;
      logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
      logic          out_v_q, out_v_d;
      logic [PW-1:0] out_pl_q, out_pl_d;
      logic          n_q, n_d, v_q, v_d, c_q, c_d, ovf_q, ovf_d;
      logic          pop, push, full, blocked;

      assign in_v        = I_FTk[k*FW + FW - 1];
      assign in_pl       = I_FTk[k*FW +: PW];
      assign bt_n        = I_BTk[k*4 + 3];
      assign bt_t        = I_BTk[k*4 + 2];
      assign unused_bt_v = I_BTk[k*4 + 1];
      assign bt_c        = I_BTk[k*4];

      always_comb begin
         pop      = out_v_q && !bt_n;
         full     = (count_q == CW'(DEPTH));
         blocked  = bt_t || (state_q == S_REVERT);
         push     = in_v && !blocked && (!full || pop);
         state_d  = state_q;
         count_d  = count_q;
         rd_ptr_d = rd_ptr_q;
         wr_ptr_d = wr_ptr_q;
         out_v_d  = out_v_q;
         out_pl_d = out_pl_q;
         mem_we   = 1'b0;
         c_d      = bt_c;
         v_d      = push;
         ovf_d    = ovf_q | (in_v && !blocked && full && !pop);
         if (bt_t) begin
            state_d  = S_REVERT;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            out_v_d  = 1'b0;
            out_pl_d = '0;
         end else begin
            if (pop) begin
               if (count_q == CW'(1)) begin
                  out_v_d  = 1'b0;
                  out_pl_d = '0;
               end else begin
                  out_pl_d = mem_q[rd_ptr_q];
                  rd_ptr_d = ptr_inc(rd_ptr_q);
               end
            end
            // A push bypasses the RAM only when the output register is (or is becoming) free.
            if (push) begin
               if (count_q == '0 || (pop && count_q == CW'(1))) begin
                  out_v_d  = 1'b1;
                  out_pl_d = in_pl;
               end else begin
                  mem_we   = 1'b1;
                  wr_ptr_d = ptr_inc(wr_ptr_q);
               end
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (state_q == S_REVERT || count_d == '0) state_d = S_EMPTY;
            else if (state_q == S_EMPTY)              state_d = S_FILL;
            else                                      state_d = bt_n ? S_WAIT : S_FILL;
         end
         n_d = (count_d >= CW'(DEPTH - SLACK));
      end

      always_ff @(posedge clock) begin
         if (mem_we) mem_q[wr_ptr_q] <= in_pl;
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            state_q  <= S_EMPTY;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            out_v_q  <= 1'b0;
            out_pl_q <= '0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
            ovf_q    <= 1'b0;
         end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            out_v_q  <= out_v_d;
            out_pl_q <= out_pl_d;
            n_q      <= n_d;
            v_q      <= v_d;
            c_q      <= c_d;
            ovf_q    <= ovf_d;
         end
      end

      assign O_FTk[k*FW +: FW] = {out_v_q, out_pl_q};
      assign O_BTk[k*4 +: 4]   = {n_q, state_q == S_REVERT, v_q, c_q};
      assign O_Overflow[k]     = ovf_q;
   end
endmodule
